ps2_ascii_decoder: RTL

Converts the PS/2 set-2 scan-code byte stream into ASCII characters and sits between the PS/2 receiver and `char_buffer`. It tracks make/break (`F0`) and extended (`E0`) prefixes, left/right shift state and caps lock. For each printable or control key press it emits exactly one ASCII byte with a one-cycle strobe. Key releases, prefixes and modifier keys emit nothing.

---
 rtl/ps2_pkg.sv | 40 ++++
 rtl/ps2_keymap.sv | 78 +++++++
 rtl/ps2_ascii_decoder.sv | 102 ++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and keymap entry helpers for the PS/2 set-2 decoder.
// Caps-lock support is compiled in only when PS2_CAPS_LOCK_EN is defined.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;
    localparam logic [7:0] PS2_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

    // letter = 1 means caps lock participates in the case choice.
    typedef struct packed {
        logic       hit;
        logic       letter;
        logic [7:0] plain;
        logic [7:0] shifted;
    } key_entry_t;

    localparam key_entry_t KEY_NONE = '{hit: 1'b0, letter: 1'b0, plain: 8'h00, shifted: 8'h00};

    function automatic key_entry_t key_letter(input logic [7:0] lower);
        return '{hit: 1'b1, letter: 1'b1, plain: lower, shifted: lower - 8'h20};
    endfunction

    function automatic key_entry_t key_pair(input logic [7:0] plain, input logic [7:0] shifted);
        return '{hit: 1'b1, letter: 1'b0, plain: plain, shifted: shifted};
    endfunction

    function automatic key_entry_t key_ctrl(input logic [7:0] code);
        return '{hit: 1'b1, letter: 1'b0, plain: code, shifted: code};
    endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Combinational US-layout lookup: set-2 make code plus shift/caps state to ASCII.
// Codes with no entry (including modifiers) report hit = 0.
module ps2_keymap
    import ps2_pkg::*;
(
    input  logic [7:0] scan_code,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii,
    output logic       hit
);

    key_entry_t w_entry;
    logic       w_upper;

    // NOTE: the default assignment before the case keeps this block latch-free.
    always_comb begin
        w_entry = KEY_NONE;
        case (scan_code)
            8'h1C: w_entry = key_letter(8'h61);
            8'h32: w_entry = key_letter(8'h62);
            8'h21: w_entry = key_letter(8'h63);
            8'h23: w_entry = key_letter(8'h64);
            8'h24: w_entry = key_letter(8'h65);
            8'h2B: w_entry = key_letter(8'h66);
            8'h34: w_entry = key_letter(8'h67);
            8'h33: w_entry = key_letter(8'h68);
            8'h43: w_entry = key_letter(8'h69);
            8'h3B: w_entry = key_letter(8'h6A);
            8'h42: w_entry = key_letter(8'h6B);
            8'h4B: w_entry = key_letter(8'h6C);
            8'h3A: w_entry = key_letter(8'h6D);
            8'h31: w_entry = key_letter(8'h6E);
            8'h44: w_entry = key_letter(8'h6F);
            8'h4D: w_entry = key_letter(8'h70);
            8'h15: w_entry = key_letter(8'h71);
            8'h2D: w_entry = key_letter(8'h72);
            8'h1B: w_entry = key_letter(8'h73);
            8'h2C: w_entry = key_letter(8'h74);
            8'h3C: w_entry = key_letter(8'h75);
            8'h2A: w_entry = key_letter(8'h76);
            8'h1D: w_entry = key_letter(8'h77);
            8'h22: w_entry = key_letter(8'h78);
            8'h35: w_entry = key_letter(8'h79);
            8'h1A: w_entry = key_letter(8'h7A);
            // Digit row: 0..9 plain, )!@#$%^&*( shifted.
            8'h45: w_entry = key_pair(8'h30, 8'h29);
            8'h16: w_entry = key_pair(8'h31, 8'h21);
            8'h1E: w_entry = key_pair(8'h32, 8'h40);
            8'h26: w_entry = key_pair(8'h33, 8'h23);
            8'h25: w_entry = key_pair(8'h34, 8'h24);
            8'h2E: w_entry = key_pair(8'h35, 8'h25);
            8'h36: w_entry = key_pair(8'h36, 8'h5E);
            8'h3D: w_entry = key_pair(8'h37, 8'h26);
            8'h3E: w_entry = key_pair(8'h38, 8'h2A);
            8'h46: w_entry = key_pair(8'h39, 8'h28);
            8'h4E: w_entry = key_pair(8'h2D, 8'h5F);
            8'h55: w_entry = key_pair(8'h3D, 8'h2B);
            8'h41: w_entry = key_pair(8'h2C, 8'h3C);
            8'h49: w_entry = key_pair(8'h2E, 8'h3E);
            8'h4A: w_entry = key_pair(8'h2F, 8'h3F);
            8'h4C: w_entry = key_pair(8'h3B, 8'h3A);
            8'h52: w_entry = key_pair(8'h27, 8'h22);
            8'h0E: w_entry = key_pair(8'h60, 8'h7E);
            8'h29: w_entry = key_ctrl(8'h20);
            8'h5A: w_entry = key_ctrl(8'h0D);
            8'h66: w_entry = key_ctrl(8'h08);
            8'h0D: w_entry = key_ctrl(8'h09);
            8'h76: w_entry = key_ctrl(8'h1B);
            default: w_entry = KEY_NONE;
        endcase
    end

    assign w_upper = w_entry.letter ? (shift ^ caps) : shift;
    assign ascii   = w_upper ? w_entry.shifted : w_entry.plain;
    assign hit     = w_entry.hit;

endmodule

// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 scan-code stream to ASCII: prefix FSM, shift/caps tracking, one strobe per mapped make.
// Define PS2_CAPS_LOCK_EN to build the caps-lock register; otherwise caps_on is tied low.
module ps2_ascii_decoder
    import ps2_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic [7:0] char_out,
    output logic       char_recv,
    output logic       caps_on
);

    ps2_state_t r_state;
    logic       r_shift_l;
    logic       r_shift_r;
    logic [7:0] r_char;
    logic       r_recv;
    logic       w_caps;
    logic       w_shift;
    logic [7:0] w_ascii;
    logic       w_hit;

`ifdef PS2_CAPS_LOCK_EN
    logic r_caps;
    assign w_caps = r_caps;
`else
    assign w_caps = 1'b0;
`endif

    assign w_shift = r_shift_l | r_shift_r;

    ps2_keymap u_keymap (
        .scan_code (scan_code),
        .shift     (w_shift),
        .caps      (w_caps),
        .ascii     (w_ascii),
        .hit       (w_hit)
    );

    // NOTE: sequential state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift_l <= 1'b0;
            r_shift_r <= 1'b0;
            r_char    <= 8'h00;
            r_recv    <= 1'b0;
`ifdef PS2_CAPS_LOCK_EN
            r_caps    <= 1'b0;
`endif
        end else begin
            r_recv <= 1'b0;
            if (scan_valid) begin
                case (r_state)
                    ST_IDLE: begin
                        if (scan_code == PS2_BREAK) begin
                            r_state <= ST_BRK;
                        end else if (scan_code == PS2_EXT) begin
                            r_state <= ST_EXT;
                        end else if (scan_code == PS2_LSHIFT) begin
                            r_shift_l <= 1'b1;
                        end else if (scan_code == PS2_RSHIFT) begin
                            r_shift_r <= 1'b1;
`ifdef PS2_CAPS_LOCK_EN
                        end else if (scan_code == PS2_CAPS) begin
                            r_caps <= ~r_caps;
`endif
                        end else if (w_hit) begin
                            r_char <= w_ascii;
                            r_recv <= 1'b1;
                        end
                    end
                    ST_BRK: begin
                        if (scan_code == PS2_LSHIFT) begin
                            r_shift_l <= 1'b0;
                        end else if (scan_code == PS2_RSHIFT) begin
                            r_shift_r <= 1'b0;
                        end
                        r_state <= ST_IDLE;
                    end
                    // Extended makes and breaks (including fake shift E0 12) are dropped.
                    ST_EXT: begin
                        r_state <= (scan_code == PS2_BREAK) ? ST_EXT_BRK : ST_IDLE;
                    end
                    ST_EXT_BRK: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign char_out  = r_char;
    assign char_recv = r_recv;
    assign caps_on   = w_caps;

endmodule
